// File: rtl/rtr_out_vc_logic.sv
// Per-output switch logic: round-robin arbitration with per-VC packet locks and credit tracking.
// Optional `RTR_OUT_PIPE_EN registers data_out/valid_out/vc_out for 1-cycle output latency.
module rtr_out_vc_logic #(
  parameter int unsigned IN_PORTS         = 4,
  parameter int unsigned FLIT_WIDTH       = 16,
  parameter int unsigned FLIT_FIELD_WIDTH = 2,
  parameter logic [FLIT_FIELD_WIDTH-1:0] FLIT_HEAD   = 2'b01,
  parameter logic [FLIT_FIELD_WIDTH-1:0] FLIT_TAIL   = 2'b10,
  parameter logic [FLIT_FIELD_WIDTH-1:0] FLIT_SINGLE = 2'b11,
  parameter int unsigned VCS              = 2,
  parameter int unsigned BUF_DEPTH        = 4,
  parameter int unsigned VC_W             = (VCS > 1) ? $clog2(VCS) : 1,
  parameter int unsigned CR_W             = $clog2(BUF_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [IN_PORTS-1:0]            sa_reqs,
  input  logic [IN_PORTS*VC_W-1:0]       sa_vc,
  input  logic [IN_PORTS*FLIT_WIDTH-1:0] data_in,
  output logic [IN_PORTS-1:0]            sa_grants,
  output logic [FLIT_WIDTH-1:0]          data_out,
  output logic                           valid_out,
  output logic [VC_W-1:0]                vc_out,
  input  logic                           credit_in,
  input  logic [VC_W-1:0]                credit_vc,
  output logic [VCS-1:0]                 vc_free,
  output logic [VCS*CR_W-1:0]            vc_credits
);

  localparam int unsigned IDX_W = (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1;

  logic [VC_W-1:0]             in_vc   [IN_PORTS];
  logic [FLIT_FIELD_WIDTH-1:0] in_type [IN_PORTS];
  logic [IN_PORTS-1:0]         eligible;
  logic [IN_PORTS-1:0]         grant;

  logic                        win_found;
  logic [IDX_W-1:0]            win_idx;
  logic [IDX_W-1:0]            cand;
  logic [VC_W-1:0]             win_vc;
  logic [FLIT_FIELD_WIDTH-1:0] win_type;
  logic [FLIT_WIDTH-1:0]       mux_data;

  logic [CR_W-1:0]  credit_q   [VCS];
  logic [CR_W-1:0]  credit_d   [VCS];
  logic [VCS-1:0]   lock_vld_q, lock_vld_d;
  logic [IDX_W-1:0] lock_own_q [VCS];
  logic [IDX_W-1:0] lock_own_d [VCS];
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [VCS-1:0]   dec_vc, inc_vc;

  logic [CR_W-1:0]  credit_at_ret;
  logic             credit_ovf;

  // Eligibility: credit available, and either owner of the lock or a packet start on a free VC.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < IN_PORTS; i++) begin
      in_vc[i]   = sa_vc[i*VC_W +: VC_W];
      in_type[i] = data_in[i*FLIT_WIDTH +: FLIT_FIELD_WIDTH];
    end
    for (int i = 0; i < IN_PORTS; i++) begin
      if (sa_reqs[i] && (int'(in_vc[i]) < VCS) && (credit_q[in_vc[i]] != '0)) begin
        if (lock_vld_q[in_vc[i]]) begin
          eligible[i] = (lock_own_q[in_vc[i]] == IDX_W'(i));
        end else begin
          eligible[i] = (in_type[i] == FLIT_HEAD) || (in_type[i] == FLIT_SINGLE);
        end
      end
    end
  end

  // Round-robin: first eligible input at or after the pointer wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < IN_PORTS; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % IN_PORTS);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    grant    = '0;
    mux_data = '0;
    for (int i = 0; i < IN_PORTS; i++) begin
      grant[i] = win_found && (win_idx == IDX_W'(i));
      mux_data = mux_data | (data_in[i*FLIT_WIDTH +: FLIT_WIDTH] & {FLIT_WIDTH{grant[i]}});
    end
    win_vc   = in_vc[win_idx];
    win_type = in_type[win_idx];
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    credit_d   = credit_q;
    dec_vc     = '0;
    inc_vc     = '0;
    if (win_found) begin
      rr_ptr_d = (win_idx == IDX_W'(IN_PORTS - 1)) ? '0 : win_idx + IDX_W'(1);
      if (win_type == FLIT_HEAD) begin
        lock_vld_d[win_vc] = 1'b1;
        lock_own_d[win_vc] = win_idx;
      end else if (win_type == FLIT_TAIL) begin
        lock_vld_d[win_vc] = 1'b0;
      end
    end
    for (int v = 0; v < VCS; v++) begin
      dec_vc[v] = win_found && (win_vc == VC_W'(v));
      inc_vc[v] = credit_in && (credit_vc == VC_W'(v));
      if (inc_vc[v] && !dec_vc[v]) begin
        // An overflowing return saturates rather than wrapping.
        if (credit_q[v] != CR_W'(BUF_DEPTH)) credit_d[v] = credit_q[v] + CR_W'(1);
      end else if (dec_vc[v] && !inc_vc[v]) begin
        credit_d[v] = credit_q[v] - CR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q   <= '0;
      lock_vld_q <= '0;
      for (int v = 0; v < VCS; v++) begin
        credit_q[v]   <= CR_W'(BUF_DEPTH);
        lock_own_q[v] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_vld_q <= lock_vld_d;
      for (int v = 0; v < VCS; v++) begin
        credit_q[v]   <= credit_d[v];
        lock_own_q[v] <= lock_own_d[v];
      end
    end
  end

  always_comb begin
    vc_credits = '0;
    for (int v = 0; v < VCS; v++) begin
      vc_credits[v*CR_W +: CR_W] = credit_q[v];
    end
  end

  assign vc_free   = ~lock_vld_q;
  assign sa_grants = grant;

`ifdef RTR_OUT_PIPE_EN
  logic [FLIT_WIDTH-1:0] data_out_q;
  logic                  valid_out_q;
  logic [VC_W-1:0]       vc_out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      vc_out_q    <= '0;
    end else begin
      data_out_q  <= mux_data;
      valid_out_q <= win_found;
      vc_out_q    <= win_found ? win_vc : '0;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign vc_out    = vc_out_q;
`else
  assign data_out  = mux_data;
  assign valid_out = win_found;
  assign vc_out    = win_found ? win_vc : '0;
`endif

  // A same-cycle grant on the returned VC makes a return at full count legal.
  assign credit_at_ret = credit_q[credit_vc];
  assign credit_ovf    = credit_in && (credit_at_ret == CR_W'(BUF_DEPTH)) &&
                         !(win_found && (win_vc == credit_vc));

  credit_no_overflow: assert property (@(posedge clk) disable iff (!rst) !credit_ovf)
    else $warning("rtr_out_vc_logic: credit overflow on VC %0d", credit_vc);

endmodule
